// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   uart_state_e          serializer FSM states (PARITY only used when the
//                         parity build option is enabled)
//   UART_IDLE_LEVEL       line level while idle and during stop bits
//   DEFAULT_CLKS_PER_BIT  50 MHz / 115200 baud
//   DATA_BITS             payload bits per frame
//   even_parity()         XOR of the data bits
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 434;
  localparam int   DATA_BITS            = 8;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter for the UART serializer.
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear_i    restart the bit period (counter to 0)
//   enable_i   count while high
//   bit_end_o  high in the final cycle of each bit period
//   pre_end_o  high in the cycle before the final one; lets the parent
//              register outputs that must line up with bit_end_o
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o,
  output logic pre_end_o
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign bit_end_o = enable_i && (cnt_q == LAST);
  assign pre_end_o = enable_i && (cnt_q == PRE);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the UART TX FIFO and shifts them out
// as 8N1 / 8N2 frames (start bit, 8 data bits LSB first, stop bits).
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   tx_enable     allows a new byte to be popped at a frame boundary
//   fifo_empty    FIFO empty flag
//   fifo_data     FIFO head byte (combinational while !fifo_empty)
//   fifo_read_en  pop strobe, one cycle per byte
//   tx            registered serial line, idle high
//   busy          high from start bit through the last stop bit
//   tx_done       one-cycle pulse in the final cycle of the last stop bit
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic bit_end;
  logic pre_end;
  logic stop_last;
  logic frame_end;
  logic load;

  // Only the last stop bit closes the frame; with one stop bit every
  // stop period is the last one.
  assign stop_last = (STOP_BITS == 1) || stop_idx_q;
  assign frame_end = (state_q == STOP) && bit_end && stop_last;
  assign load      = tx_enable && !fifo_empty && ((state_q == IDLE) || frame_end);

  // Gated with reset so the FIFO never advances while we are held in reset.
  assign fifo_read_en = load && reset;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .clear_i   (load),
    .enable_i  (state_q != IDLE),
    .bit_end_o (bit_end),
    .pre_end_o (pre_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      // Registered one cycle early so the pulse lands on the final stop cycle.
      done_q <= (state_q == STOP) && stop_last && pre_end;

      if (load) begin
        shift_q    <= fifo_data;
        tx_q       <= ~UART_IDLE_LEVEL;
        state_q    <= START;
        busy_q     <= 1'b1;
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_q   <= even_parity(fifo_data);
`endif
      end else begin
        case (state_q)
          START: if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
          DATA: if (bit_end) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= UART_IDLE_LEVEL;
`endif
            end else begin
              tx_q <= shift_q[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: if (bit_end) begin
            state_q <= STOP;
            tx_q    <= UART_IDLE_LEVEL;
          end
`endif
          STOP: if (bit_end) begin
            if (stop_last) begin
              // Back-to-back frames are taken by the load branch above.
              state_q <= IDLE;
              tx_q    <= UART_IDLE_LEVEL;
              busy_q  <= 1'b0;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit-side consumer of the UART FIFO buffer: pops bytes from the FIFO read port and serializes each one onto the tx line.
- Frame format 8N1: one start bit, 8 data bits LSB first, STOP_BITS stop bits.
- Sits between the UART TX FIFO and the pad, under the UART peripheral register block that drives tx_enable.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200 baud); legal range 2 or greater.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- tx_enable  in  1  permits popping a new byte; sampled only at frame boundaries.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO head byte, valid combinationally while !fifo_empty.
- fifo_read_en  out  1  FIFO pop strobe; one cycle per byte.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  high from start bit through the end of the last stop bit.
- tx_done  out  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset values: tx=1, busy=0, tx_done=0, state=IDLE, counters=0, shift register=0. fifo_read_en is forced to 0 while reset=0.
- States: IDLE, START, DATA, STOP, plus PARITY when the optional feature is compiled in.
- Load condition: tx_enable && !fifo_empty && (state==IDLE || last cycle of STOP).
  - fifo_read_en = load condition (combinational).
  - On the same edge: latch fifo_data into an 8-bit shift register, tx<=0, state<=START, bit timer cleared.
  - The FIFO pointer advances on that same edge.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. A 3-bit index counts 0..7; after bit 7 go to STOP (or PARITY).
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 in the final cycle. Then:
  - if the load condition holds: back-to-back, no idle gap, go to START;
  - otherwise go to IDLE.
- Frame length: (1+8+STOP_BITS)*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity).
- First start-bit cycle is the cycle after the pop edge.
- Bit timer: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- tx_enable deasserted mid-frame: current frame completes; no further pop.
- fifo_empty asserted mid-frame: no effect until the frame boundary.
- Reset asserted mid-frame: immediate return to the reset values. The byte already popped is discarded, never retransmitted.
- fifo_data is ignored outside the load cycle. The serializer never pops while fifo_empty=1.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP; tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Parity is computed at load and held in a register.
- Undefined: no PARITY state and no parity register; frame is 8N1/8N2.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - UART_IDLE_LEVEL=1;
  - DEFAULT_CLKS_PER_BIT=434;
  - DATA_BITS=8.
- One natural sub-module, uart_bit_timer:
  - parameterised by CLKS_PER_BIT;
  - inputs clear and enable;
  - output bit_end, high in the final cycle of each bit period.
- The FSM, shift register and output registers stay in uart_tx_serializer.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1 unless noted):
- FIFO holds 0xA5, tx_enable=1 -> exactly one fifo_read_en pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high 40 cycles; one tx_done pulse in cycle 40.
- FIFO holds 0x00 then 0xFF -> two pops exactly 40 cycles apart; tx never high between stop bit and next start bit; busy continuous for 80 cycles; two tx_done pulses.
- fifo_empty=1 with tx_enable=1 for 100 cycles -> tx=1, busy=0, fifo_read_en never asserted.
- tx_enable dropped during DATA of 0x3C, FIFO still non-empty -> frame completes correctly; no second pop; IDLE after the stop bit.
- reset driven to 0 during DATA bit 3 -> tx=1 and busy=0 immediately, without a clock edge. After release with FIFO non-empty: next byte popped and transmitted cleanly, interrupted byte not resent.
- UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 after the data bits; frame 44 cycles. Byte 0x03 -> parity bit 0.
